// File: rtl/string_gen_pkg.sv
// string_pkg: shared definitions for the expression-string generator and
// the matching recognizer.
//   - state_e  : generator FSM states (ST_TERM exists only when
//                STRING_GEN_TERM_EN is defined)
//   - CH_*     : ASCII codes for the expression alphabet
package string_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIGIT = 2'd1,
    ST_OP    = 2'd2
`ifdef STRING_GEN_TERM_EN
    ,
    ST_TERM  = 2'd3
`endif
  } state_e;

  localparam logic [7:0] CH_NUL  = 8'h00;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;
  localparam logic [7:0] CH_EQ   = 8'h3D;

endpackage

// File: rtl/string_gen_if.sv
// string_gen_if: operand/control inputs plus the character stream handshake
// of string_gen.
//   master : drives start, n_terms, digits, ops, out_ready
//   slave  : string_gen itself; drives out, out_valid, busy, done, err
// MAX_TERMS must match the MAX_TERMS of the attached string_gen.
interface string_gen_if #(
  parameter int MAX_TERMS = 8
);
  localparam int N_W   = $clog2(MAX_TERMS + 1);
  // A single-term build has no operators; keep one dummy bit so the vector
  // stays legal.
  localparam int OPS_W = (MAX_TERMS > 1) ? MAX_TERMS - 1 : 1;

  logic                   start;
  logic [N_W-1:0]         n_terms;
  logic [4*MAX_TERMS-1:0] digits;
  logic [OPS_W-1:0]       ops;
  logic [7:0]             out;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;
  logic                   done;
  logic                   err;

  modport master (
    output start, n_terms, digits, ops, out_ready,
    input  out, out_valid, busy, done, err
  );

  modport slave (
    input  start, n_terms, digits, ops, out_ready,
    output out, out_valid, busy, done, err
  );

endinterface

// File: rtl/string_gen_char_enc.sv
// string_char_enc: combinational ASCII encoder for one stream symbol.
//   is_op_i  : 1 = operator symbol, 0 = digit symbol
//   op_bit_i : operator select, 0 = '+', 1 = '*'
//   digit_i  : BCD digit (only meaningful when is_op_i = 0)
//   char_o   : ASCII code
module string_char_enc
  import string_pkg::*;
(
  input  logic       is_op_i,
  input  logic       op_bit_i,
  input  logic [3:0] digit_i,
  output logic [7:0] char_o
);

  always_comb begin
    if (is_op_i) begin
      char_o = op_bit_i ? CH_MUL : CH_PLUS;
    end else begin
      char_o = CH_0 + {4'd0, digit_i};
    end
  end

endmodule

// File: rtl/string_gen.sv
// string_gen: serialises a latched arithmetic expression (BCD digits joined
// by '+'/'*') into ASCII characters, one per out_valid/out_ready handshake.
// Ports:
//   clk   : rising-edge clock
//   clr_n : synchronous active-low clear
//   bus   : string_gen_if.slave (start/n_terms/digits/ops in,
//           out/out_valid out, out_ready in, busy/done/err out)
// Build option: STRING_GEN_TERM_EN appends a trailing '=' after the last
// digit and pulses done only after it has been taken.
// All outputs come straight from registers; their next values are derived
// from the next state so the first character appears the cycle after start.
module string_gen
  import string_pkg::*;
#(
  parameter int MAX_TERMS = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  string_gen_if.slave  bus
);

  localparam int N_W   = $clog2(MAX_TERMS + 1);
  localparam int OPS_W = (MAX_TERMS > 1) ? MAX_TERMS - 1 : 1;
  // Lookup tables are padded to the full index range so an N_W-bit index
  // never selects outside them.
  localparam int SLOTS = 1 << N_W;

  state_e                 state_q, state_d;
  logic [N_W-1:0]         n_q, n_d;
  logic [N_W-1:0]         idx_q, idx_d;
  logic [4*MAX_TERMS-1:0] digits_q, digits_d;
  logic [OPS_W-1:0]       ops_q, ops_d;
  logic [7:0]             out_q, out_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  // Start validation: only the digits actually used must be BCD.
  logic [MAX_TERMS-1:0] bad_digit;
  logic                 start_ok;

  generate
    for (genvar gi = 0; gi < MAX_TERMS; gi++) begin : g_chk
      assign bad_digit[gi] = (N_W'(gi) < bus.n_terms) &&
                             (bus.digits[4*gi +: 4] > 4'd9);
    end
  endgenerate

  assign start_ok = (bus.n_terms != '0) &&
                    (bus.n_terms <= N_W'(MAX_TERMS)) &&
                    !(|bad_digit);

  // Symbol tables indexed by the next term index.
  logic [SLOTS-1:0][3:0] digit_slot;
  logic [SLOTS-1:0]      op_slot;

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi < MAX_TERMS) begin : g_dig
        assign digit_slot[gi] = digits_d[4*gi +: 4];
      end else begin : g_dig_pad
        assign digit_slot[gi] = 4'd0;
      end
      if (gi < MAX_TERMS - 1) begin : g_op
        assign op_slot[gi] = ops_d[gi];
      end else begin : g_op_pad
        assign op_slot[gi] = 1'b0;
      end
    end
  endgenerate

  // Next-state logic. In every non-IDLE state out_valid is high, so a
  // handshake reduces to out_ready.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    idx_d    = idx_q;
    digits_d = digits_q;
    ops_d    = ops_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (start_ok) begin
            n_d      = bus.n_terms;
            digits_d = bus.digits;
            ops_d    = bus.ops;
            idx_d    = '0;
            state_d  = ST_DIGIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_DIGIT: begin
        if (bus.out_ready) begin
          if (idx_q == n_q - N_W'(1)) begin
`ifdef STRING_GEN_TERM_EN
            state_d = ST_TERM;
`else
            state_d = ST_IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = ST_OP;
          end
        end
      end
      ST_OP: begin
        if (bus.out_ready) begin
          idx_d   = idx_q + N_W'(1);
          state_d = ST_DIGIT;
        end
      end
`ifdef STRING_GEN_TERM_EN
      ST_TERM: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  logic [7:0] enc_char;

  string_char_enc u_enc (
    .is_op_i  (state_d == ST_OP),
    .op_bit_i (op_slot[idx_d]),
    .digit_i  (digit_slot[idx_d]),
    .char_o   (enc_char)
  );

  // Output values for the cycle after this edge.
  always_comb begin
    out_valid_d = (state_d != ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    case (state_d)
      ST_IDLE: out_d = CH_NUL;
`ifdef STRING_GEN_TERM_EN
      ST_TERM: out_d = CH_EQ;
`endif
      default: out_d = enc_char;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      idx_q       <= '0;
      digits_q    <= '0;
      ops_q       <= '0;
      out_q       <= CH_NUL;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      digits_q    <= digits_d;
      ops_q       <= ops_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_string_gen.sv
// tb_string_gen: directed self-checking bench for string_gen.
// Expected characters are hand-written per scenario; when
// STRING_GEN_TERM_EN is defined each stream gains a trailing '='.
module tb_string_gen;
  import string_pkg::*;

  localparam int MT = 8;
  localparam int NW = $clog2(MT + 1);

  logic clk   = 1'b0;
  logic clr_n = 1'b0;

  string_gen_if #(.MAX_TERMS(MT)) bus ();

  string_gen #(.MAX_TERMS(MT)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Advance past the next rising edge; samples and drives happen here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a start for exactly one edge; on return the first character
  // (or the err pulse) is visible.
  task automatic launch(input int n, input logic [31:0] d, input logic [6:0] o);
    bus.n_terms = NW'(n);
    bus.digits  = d;
    bus.ops     = o;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    tick();
    tick();
    vectors++;
    if ({bus.out, bus.out_valid, bus.busy, bus.done, bus.err} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset: out=%h valid=%b busy=%b done=%b err=%b, need all zero",
               bus.out, bus.out_valid, bus.busy, bus.done, bus.err);
    end
    clr_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [7:0] exp[$] = '{8'h37};
`ifdef STRING_GEN_TERM_EN
    exp.push_back(CH_EQ);
`endif
    bus.out_ready = 1'b1;
    launch(1, 32'h0000_0007, 7'b0);
    for (int i = 0; i < exp.size(); i++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1 || bus.out !== exp[i]) begin
        miscompares++;
        $display("FAIL single char%0d: out=%h valid=%b busy=%b, need %h 1 1",
                 i, bus.out, bus.out_valid, bus.busy, exp[i]);
      end
      tick();
    end
    vectors++;
    if (bus.done !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single done: done=%b valid=%b busy=%b, need 1 0 0",
               bus.done, bus.out_valid, bus.busy);
    end
    tick();
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL single done_pulse: done=%b, need 0", bus.done);
    end
  endtask

  task automatic test_three();
    logic [7:0] exp[$] = '{8'h31, 8'h2B, 8'h32, 8'h2A, 8'h33};
`ifdef STRING_GEN_TERM_EN
    exp.push_back(CH_EQ);
`endif
    bus.out_ready = 1'b1;
    launch(3, 32'h0000_0321, 7'b0000010);
    for (int i = 0; i < exp.size(); i++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1 || bus.out !== exp[i]) begin
        miscompares++;
        $display("FAIL three char%0d: out=%h valid=%b busy=%b, need %h 1 1",
                 i, bus.out, bus.out_valid, bus.busy, exp[i]);
      end
      tick();
    end
    vectors++;
    if (bus.done !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL three done: done=%b valid=%b busy=%b, need 1 0 0",
               bus.done, bus.out_valid, bus.busy);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] exp[$] = '{8'h2B, 8'h32, 8'h2A, 8'h33};
`ifdef STRING_GEN_TERM_EN
    exp.push_back(CH_EQ);
`endif
    bus.out_ready = 1'b1;
    launch(3, 32'h0000_0321, 7'b0000010);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out !== 8'h31) begin
      miscompares++;
      $display("FAIL bp first: out=%h valid=%b, need 31 1", bus.out, bus.out_valid);
    end
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out !== 8'h2B) begin
        miscompares++;
        $display("FAIL bp hold%0d: out=%h valid=%b, need 2b 1", i, bus.out, bus.out_valid);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < exp.size(); i++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out !== exp[i]) begin
        miscompares++;
        $display("FAIL bp char%0d: out=%h valid=%b, need %h 1", i, bus.out, bus.out_valid, exp[i]);
      end
      tick();
    end
    vectors++;
    if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp done: done=%b valid=%b, need 1 0", bus.done, bus.out_valid);
    end
    tick();
  endtask

  task automatic test_errors();
    int          n_tab[3] = '{0, 2, 9};
    logic [31:0] d_tab[3] = '{32'h0000_0001, 32'h0000_00A1, 32'h1111_1111};
    bus.out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      launch(n_tab[t], d_tab[t], 7'b0);
      vectors++;
      if (bus.err !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL err%0d pulse: err=%b valid=%b busy=%b, need 1 0 0",
                 t, bus.err, bus.out_valid, bus.busy);
      end
      tick();
      vectors++;
      if (bus.err !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL err%0d after: err=%b valid=%b busy=%b, need 0 0 0",
                 t, bus.err, bus.out_valid, bus.busy);
      end
    end
  endtask

  // An out-of-range digit beyond N must not cause a rejection.
  task automatic test_unused_digit();
    logic [7:0] exp[$] = '{8'h33, 8'h2B, 8'h34};
`ifdef STRING_GEN_TERM_EN
    exp.push_back(CH_EQ);
`endif
    bus.out_ready = 1'b1;
    launch(2, 32'h0000_0F43, 7'b0);
    for (int i = 0; i < exp.size(); i++) begin
      vectors++;
      if (bus.err !== 1'b0 || bus.out_valid !== 1'b1 || bus.out !== exp[i]) begin
        miscompares++;
        $display("FAIL unused char%0d: out=%h valid=%b err=%b, need %h 1 0",
                 i, bus.out, bus.out_valid, bus.err, exp[i]);
      end
      tick();
    end
    vectors++;
    if (bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL unused done: done=%b, need 1", bus.done);
    end
    tick();
  endtask

  task automatic test_clear();
    logic [7:0] exp[$] = '{8'h35, 8'h2A, 8'h39};
`ifdef STRING_GEN_TERM_EN
    exp.push_back(CH_EQ);
`endif
    bus.out_ready = 1'b1;
    launch(4, 32'h0000_4321, 7'b0);
    tick();
    vectors++;
    if (bus.out !== 8'h2B || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL clr op: out=%h valid=%b, need 2b 1", bus.out, bus.out_valid);
    end
    clr_n = 1'b0;
    tick();
    vectors++;
    if ({bus.out, bus.out_valid, bus.busy, bus.done, bus.err} !== 12'h000) begin
      miscompares++;
      $display("FAIL clr outputs: out=%h valid=%b busy=%b done=%b err=%b, need all zero",
               bus.out, bus.out_valid, bus.busy, bus.done, bus.err);
    end
    clr_n = 1'b1;
    tick();
    vectors++;
    if (bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL clr idle: done=%b valid=%b, need 0 0", bus.done, bus.out_valid);
    end
    launch(2, 32'h0000_0095, 7'b0000001);
    for (int i = 0; i < exp.size(); i++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out !== exp[i]) begin
        miscompares++;
        $display("FAIL clr restart char%0d: out=%h valid=%b, need %h 1",
                 i, bus.out, bus.out_valid, exp[i]);
      end
      tick();
    end
    vectors++;
    if (bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL clr restart done: done=%b, need 1", bus.done);
    end
    tick();
  endtask

  // Inputs change and start is re-asserted mid-stream; only the latched
  // expression may come out and no err may be raised.
  task automatic test_ignore_inputs();
    logic [7:0] exp[$] = '{8'h31, 8'h2B, 8'h32, 8'h2A, 8'h33};
`ifdef STRING_GEN_TERM_EN
    exp.push_back(CH_EQ);
`endif
    bus.out_ready = 1'b1;
    launch(3, 32'h0000_0321, 7'b0000010);
    bus.start   = 1'b1;
    bus.n_terms = NW'(1);
    bus.digits  = 32'h8888_8888;
    bus.ops     = 7'b1111111;
    for (int i = 0; i < exp.size(); i++) begin
      if (i == exp.size() - 1) bus.start = 1'b0;
      vectors++;
      if (bus.err !== 1'b0 || bus.out_valid !== 1'b1 || bus.out !== exp[i]) begin
        miscompares++;
        $display("FAIL ignore char%0d: out=%h valid=%b err=%b, need %h 1 0",
                 i, bus.out, bus.out_valid, bus.err, exp[i]);
      end
      tick();
    end
    vectors++;
    if (bus.done !== 1'b1 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore done: done=%b err=%b, need 1 0", bus.done, bus.err);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp1[$] = '{8'h30};
    logic [7:0] exp2[$] = '{8'h39, 8'h2B, 8'h30};
`ifdef STRING_GEN_TERM_EN
    exp1.push_back(CH_EQ);
    exp2.push_back(CH_EQ);
`endif
    bus.out_ready = 1'b1;
    launch(1, 32'h0000_0000, 7'b0);
    for (int i = 0; i < exp1.size(); i++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out !== exp1[i]) begin
        miscompares++;
        $display("FAIL b2b first char%0d: out=%h valid=%b, need %h 1",
                 i, bus.out, bus.out_valid, exp1[i]);
      end
      tick();
    end
    vectors++;
    if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b bubble: done=%b valid=%b, need 1 0", bus.done, bus.out_valid);
    end
    launch(2, 32'h0000_0009, 7'b0);
    for (int i = 0; i < exp2.size(); i++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1 || bus.out !== exp2[i]) begin
        miscompares++;
        $display("FAIL b2b second char%0d: out=%h valid=%b busy=%b, need %h 1 1",
                 i, bus.out, bus.out_valid, bus.busy, exp2[i]);
      end
      tick();
    end
    vectors++;
    if (bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b done: done=%b, need 1", bus.done);
    end
    tick();
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.n_terms   = '0;
    bus.digits    = '0;
    bus.ops       = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_three();
    test_backpressure();
    test_errors();
    test_unused_digit();
    test_clear();
    test_ignore_inputs();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, need completion", $time);
    $fatal(1, "timeout");
  end

endmodule
